// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default geometry and
// the FSM state encoding.
package imem_loader_pkg;

  localparam int N_DEF        = 16;
  localparam int DEPTH_DEF    = 64;
  localparam int ADDR_W_DEF   = 6;
  localparam int PC_SHIFT_DEF = 1;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t RUN  = 2'd2;

endpackage

// File: rtl/imem_loader_if.sv
// Host-to-loader program word stream (valid/ready with end-of-program marker).
interface imem_loader_if #(
  parameter int n = 16
);

  logic         ld_valid;
  logic         ld_ready;
  logic [n-1:0] ld_data;
  logic         ld_last;

  modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
  modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);

endinterface

// File: rtl/imem_ram.sv
// Instruction RAM: synchronous write, asynchronous read, contents survive reset.
module imem_ram #(
  parameter int n      = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [n-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [n-1:0]      rdata
);

  logic [n-1:0] mem [DEPTH];

  // Store one program word per accepted transfer.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a program from the host into the instruction RAM while holding the CPU
// in reset, then releases the CPU and serves instructions combinationally.
//
// state | meaning
// IDLE  | no valid program (after reset or overflow); CPU held in reset
// LOAD  | accepting host words into RAM; CPU held in reset
// RUN   | program loaded; CPU released, instr served from pc
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int n        = N_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PC_SHIFT = PC_SHIFT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  imem_loader_if.slave    ld,
  input  logic [n-1:0]    pc,
  output logic [n-1:0]    instr,
  output logic            cpu_reset,
  output logic            load_err,
  output logic [ADDR_W:0] words_loaded
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [n-1:0]      DEPTH_N  = n'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              ld_ready_q;
  logic              xfer;
  logic              at_end;
  logic [n-1:0]      idx;
  logic [n-1:0]      rdata;
  logic              hit;

  assign ld.ld_ready = ld_ready_q;
  assign xfer        = ld.ld_valid & ld_ready_q & (state == LOAD);
  assign at_end      = (wr_ptr == LAST_PTR);

  // Sequencing FSM; ld_ready and cpu_reset are registered so they change
  // exactly on state entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      words_loaded <= '0;
      load_err     <= 1'b0;
      cpu_reset    <= 1'b1;
      ld_ready_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (start) begin
            state        <= LOAD;
            wr_ptr       <= '0;
            words_loaded <= '0;
            load_err     <= 1'b0;
            cpu_reset    <= 1'b1;
            ld_ready_q   <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            wr_ptr       <= wr_ptr + ADDR_W'(1);
            words_loaded <= {1'b0, wr_ptr} + (ADDR_W + 1)'(1);
            if (ld.ld_last) begin
              // last word wins over the full condition: a full load is valid
              state      <= RUN;
              cpu_reset  <= 1'b0;
              ld_ready_q <= 1'b0;
            end else if (at_end) begin
              state      <= IDLE;
              load_err   <= 1'b1;
              ld_ready_q <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          cpu_reset  <= 1'b1;
          ld_ready_q <= 1'b0;
        end
      endcase
    end
  end

  imem_ram #(
    .n      (n),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (xfer),
    .waddr (wr_ptr),
    .wdata (ld.ld_data),
    .raddr (idx[ADDR_W-1:0]),
    .rdata (rdata)
  );

  // pc is a byte address; anything outside the loaded program reads as 0.
  assign idx   = pc >> PC_SHIFT;
  assign hit   = (state == RUN) && (idx < n'(words_loaded)) && (idx < DEPTH_N);
  assign instr = hit ? rdata : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized directed bench for imem_loader with a word-level reference model.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] pc;
  logic [15:0] instr;
  logic        cpu_reset;
  logic        load_err;
  logic [6:0]  words_loaded;

  imem_loader_if #(.n(16)) ld ();

  imem_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ld           (ld),
    .pc           (pc),
    .instr        (instr),
    .cpu_reset    (cpu_reset),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: what the CPU should currently see
  logic [15:0] m_mem [64];
  int          m_wl  = 0;
  bit          m_run = 0;
  bit          m_err = 0;
  logic [15:0] wbuf  [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_instr(input logic [15:0] p);
    int w;
    w = int'(p) / 2;
    if (!m_run || w >= m_wl || w >= 64) return 16'h0;
    return m_mem[w];
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    m_run = 0; m_wl = 0; m_err = 0;
    #1;
    check("start_ld_ready", ld.ld_ready, 1);
    check("start_cpu_reset", cpu_reset, 1);
    check("start_words_loaded", words_loaded, 0);
    check("start_load_err", load_err, 0);
    check("start_instr", instr, 0);
  endtask

  // mode 0: valid every cycle, 1: alternate valid/stall, 2: random stalls
  task automatic stream(input int k, input bit with_last, input int mode, input bit poke_start);
    int i = 0;
    int cyc = 0;
    bit v;
    while (i < k && cyc < 4 * k + 20) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      ld.ld_valid = v;
      ld.ld_data  = v ? wbuf[i] : 16'($urandom);
      ld.ld_last  = v ? (with_last && i == k - 1) : 1'($urandom);
      start       = poke_start ? ($urandom_range(0, 3) == 0) : 1'b0;
      #1;
      check("load_ld_ready", ld.ld_ready, 1);
      check("load_cpu_reset", cpu_reset, 1);
      @(posedge clk);
      @(negedge clk);
      if (v) begin
        i++;
        check("load_words_loaded", words_loaded, 32'(i));
      end
      cyc++;
    end
    ld.ld_valid = 1'b0;
    ld.ld_last  = 1'b0;
    start       = 1'b0;
    if (i < k) check("stream_budget", 32'(i), 32'(k));
    for (int j = 0; j < k; j++) m_mem[j] = wbuf[j];
    m_wl  = k;
    m_run = with_last;
    m_err = !with_last && (k == 64);
    #1;
    check("end_ld_ready", ld.ld_ready, 0);
    check("end_cpu_reset", cpu_reset, m_run ? 0 : 1);
    check("end_load_err", load_err, m_err);
    check("end_words_loaded", words_loaded, 32'(m_wl));
  endtask

  task automatic sweep(input int upto);
    for (int p = 0; p <= upto; p += 2) begin
      @(negedge clk);
      pc = 16'(p);
      #1;
      check("instr_sweep", instr, exp_instr(pc));
    end
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      pc = 16'($urandom);
      if (r < 3) pc = 16'($urandom_range(0, 2 * m_wl + 3));
      #1;
      check("instr_rand_pc", instr, exp_instr(pc));
    end
  endtask

  task automatic fill_random(input int k);
    for (int j = 0; j < k; j++) wbuf[j] = 16'($urandom);
  endtask

  task automatic check_pc(input logic [15:0] p, input logic [15:0] exp, input string tag);
    @(negedge clk);
    pc = p;
    #1;
    check(tag, instr, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    pc = '0;
    ld.ld_valid = 1'b0;
    ld.ld_data = '0;
    ld.ld_last = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_ld_ready", ld.ld_ready, 0);
    check("rst_words_loaded", words_loaded, 0);
    check("rst_load_err", load_err, 0);
    check("rst_instr", instr, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("idle_ld_ready", ld.ld_ready, 0);
    check("idle_cpu_reset", cpu_reset, 1);

    // three-word program, valid every cycle
    wbuf[0] = 16'h6208; wbuf[1] = 16'h5F04; wbuf[2] = 16'h5E02;
    pulse_start();
    stream(3, 1'b1, 0, 1'b0);
    check_pc(16'd0, 16'h6208, "p3_pc0");
    check_pc(16'd2, 16'h5F04, "p3_pc2");
    check_pc(16'd4, 16'h5E02, "p3_pc4");
    check_pc(16'd6, 16'h0000, "p3_pc6");

    // same program reloaded from RUN with alternating stalls
    pulse_start();
    stream(3, 1'b1, 1, 1'b0);
    check_pc(16'd0, 16'h6208, "stall_pc0");
    check_pc(16'd2, 16'h5F04, "stall_pc2");
    check_pc(16'd4, 16'h5E02, "stall_pc4");
    sweep(10);

    // random short program, random stalls, stray start pulses mid-load
    fill_random(int'($urandom_range(2, 12)));
    begin
      int k = int'($urandom_range(2, 12));
      fill_random(k);
      pulse_start();
      stream(k, 1'b1, 2, 1'b1);
      sweep(2 * k + 4);
    end

    // overflow: 64 words without last
    fill_random(64);
    pulse_start();
    stream(64, 1'b0, 0, 1'b0);
    ld.ld_valid = 1'b1;
    ld.ld_last  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("ovf_idle_ld_ready", ld.ld_ready, 0);
    check("ovf_idle_words_loaded", words_loaded, 64);
    check("ovf_idle_load_err", load_err, 1);
    ld.ld_valid = 1'b0;
    ld.ld_last  = 1'b0;
    sweep(130);

    // full load with last on word 64
    fill_random(64);
    pulse_start();
    stream(64, 1'b1, 2, 1'b0);
    check_pc(16'd126, wbuf[63], "full_pc126");
    check_pc(16'd128, 16'h0000, "full_pc128");
    sweep(20);

    // reload a single word from RUN
    wbuf[0] = 16'h6208; wbuf[1] = 16'h5F04; wbuf[2] = 16'h5E02;
    pulse_start();
    stream(3, 1'b1, 0, 1'b0);
    wbuf[0] = 16'h1234;
    pulse_start();
    stream(1, 1'b1, 0, 1'b0);
    check_pc(16'd0, 16'h1234, "one_pc0");
    check_pc(16'd2, 16'h0000, "one_pc2");
    check("one_words_loaded", words_loaded, 1);

    // reset mid-load after two transfers
    pulse_start();
    for (int j = 0; j < 2; j++) begin
      ld.ld_valid = 1'b1;
      ld.ld_data  = 16'($urandom);
      ld.ld_last  = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    ld.ld_valid = 1'b0;
    #1;
    check("pre_rst_words_loaded", words_loaded, 2);
    check("pre_rst_ld_ready", ld.ld_ready, 1);
    #1;
    reset = 1'b0;
    m_run = 0; m_wl = 0; m_err = 0;
    #1;
    check("midrst_cpu_reset", cpu_reset, 1);
    check("midrst_ld_ready", ld.ld_ready, 0);
    check("midrst_words_loaded", words_loaded, 0);
    check("midrst_instr", instr, 0);
    @(negedge clk);
    reset = 1'b1;
    ld.ld_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post_rst_ld_ready", ld.ld_ready, 0);
    check("post_rst_words_loaded", words_loaded, 0);
    ld.ld_valid = 1'b0;
    begin
      int k = int'($urandom_range(3, 8));
      fill_random(k);
      pulse_start();
      stream(k, 1'b1, 2, 1'b0);
      sweep(2 * k + 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
